nano_spi_master: RTL and testbench
==================================

# nano_spi_master

SPI master (initiator) driving the Nano microcontroller system's SPI slave port (SCK, MOSI, CS in; MISO out) from a host-side byte stream. It is used for program/data loading and readback of the Nano core in bring-up, test-harness and multi-chip configurations. The block serialises bytes in SPI mode 0, MSB first, and holds CS across multi-byte frames. A valid/ready byte interface faces the host logic.

## Interface
- CLK_DIV, default 4: SCK half-period in CLK cycles; legal range 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- NRST  in  1  asynchronous, active-low reset.
- TX_DATA  in  8  byte to transmit, MSB first.
- TX_LAST  in  1  with TX_DATA; 1 = release CS after this byte.
- TX_VALID  in  1  TX_DATA/TX_LAST valid.
- TX_READY  out  1  byte accepted on a cycle with TX_VALID & TX_READY.
- RX_DATA  out  8  byte shifted in from MISO; holds until the next byte completes.
- RX_VALID  out  1  one-cycle pulse, RX_DATA new.
- BUSY  out  1  high whenever CS is asserted or CS recovery is in progress.
- SPI_SCK  out  1  serial clock, idle low.
- SPI_MOSI  out  1  serial data to slave.
- SPI_CS  out  1  chip select, active low, idle high.
- SPI_MISO  in  1  serial data from slave; synchronous to SCK, sampled on the SCK rising edge.

## Operation
- States: IDLE, SHIFT, WAIT, HOLD, RECOV.
- IDLE: CS=1, SCK=0. TX_READY=1. A handshake loads the shift register and latches TX_LAST. Next state: SHIFT.
- SHIFT:
  - CS=0. SCK toggles every CLK_DIV cycles, 8 full periods.
  - MOSI presents the current MSB. It is updated on each SCK falling edge.
  - MISO is shifted in at each SCK rising edge.
  - After the 8th falling edge: RX_VALID pulses. Next state is HOLD if the latched last flag is 1, else WAIT.
- WAIT: CS stays 0, SCK=0. TX_READY=1.
  - A handshake loads the next byte and returns to SHIFT.
  - With no TX_VALID, the block waits indefinitely with CS held low.
- HOLD: CLK_DIV cycles with CS=0, SCK=0 (CS hold time). Then CS=1 and the state moves to RECOV.
- RECOV: CLK_DIV cycles with CS=1 (minimum CS-high time). Then IDLE.
- TX_READY is combinational from state: 1 in IDLE/WAIT only. TX_VALID is ignored in all other states.
- BUSY = state != IDLE.
- Reset values (NRST=0): state IDLE, SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, RX_DATA=0, RX_VALID=0, BUSY=0. TX_READY reads 1 during reset, but no handshake is taken while NRST=0.
- Reset mid-byte aborts immediately: CS releases asynchronously and the partial RX byte is discarded. No RX_VALID is produced.
- TX_DATA/TX_LAST may change freely after the handshake; the block uses only the latched copies.

## Timing
- Cycle numbering: the handshake is at cycle 0.
- Cycle 1: CS=0, MOSI=bit7, SCK=0.
- SCK rising edge k (k=1..8): cycle 1+(2k−1)·CLK_DIV. SCK falling edge k: cycle 1+2k·CLK_DIV.
- MISO is captured on the CLK edge that drives SCK high.
- RX_VALID: cycle 1+16·CLK_DIV, the same cycle as the 8th falling edge.
- Back-to-back within a frame: if TX_VALID is high on the first WAIT cycle (1+16·CLK_DIV), the next byte's MOSI=bit7 appears one cycle later. Byte pitch is 16·CLK_DIV+1 cycles.
- Last byte: CS rises at cycle 1+17·CLK_DIV. TX_READY returns at 1+18·CLK_DIV.
- Half-period counter width is 8 bits. It reloads to CLK_DIV−1 on every SCK edge and on every state entry.

## Configuration
- NANO_SPI_RX_EN defined: the MISO sampling shift register, RX_DATA and RX_VALID are implemented as specified.
- NANO_SPI_RX_EN undefined:
  - RX_DATA is tied to 0 and RX_VALID to 0; SPI_MISO is unused (lint-waived).
  - TX timing is identical in both builds.

## Structure
- Package nano_spi_pkg holds:
  - the state enum (IDLE, SHIFT, WAIT, HOLD, RECOV);
  - the byte width constant (8);
  - the bit-count width constant (4).
- Sub-module nano_spi_halfcnt: a loadable down-counter that emits a one-cycle tick when it reaches 0. It is shared by the SHIFT, HOLD and RECOV timing.
- The top holds the FSM, TX/RX shift registers and output registers. All SPI outputs are driven directly from flops (no combinational glitches).

## Test plan
- Single byte, CLK_DIV=2, TX_DATA=0xA5, TX_LAST=1, slave returns 0x3C:
  - 8 SCK pulses, MOSI bits 1,0,1,0,0,1,0,1;
  - RX_VALID at cycle 33 with RX_DATA=0x3C;
  - CS high at cycle 35, TX_READY at cycle 37.
- Three-byte frame 0x01,0x02,0x83 (LAST on third), TX_VALID held high:
  - CS low continuously for all 24 SCK periods;
  - byte pitch 33 cycles;
  - exactly one CS rising edge.
- Frame stall: second byte presented 50 cycles late → CS stays low, SCK stays low through WAIT, and the transfer resumes with correct bits.
- NRST pulsed low during the 5th SCK high phase → SPI_CS=1, SCK=0, MOSI=0 immediately; no RX_VALID; the next transfer after reset is clean.
- CLK_DIV=1 with 0xFF/0x00 alternation → SCK toggles every cycle and MOSI/MISO data stays correct.
- Build without NANO_SPI_RX_EN, MISO=1 → RX_VALID never asserts, RX_DATA=0, and MOSI/SCK/CS waveforms are identical to the RX build.

Source files
------------

// File: rtl/nano_spi_pkg.sv
// Shared types and constants for the Nano SPI master.
// Optional RX path is enabled by defining NANO_SPI_RX_EN.
package nano_spi_pkg;

  localparam int BYTE_W = 8;
  localparam int BIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    HOLD,
    RECOV
  } state_t;

endpackage

// File: rtl/nano_spi_halfcnt.sv
// Loadable down-counter; tick is high while the count sits at zero.
// Shared by SCK half-period, CS hold and CS recovery timing.
module nano_spi_halfcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/nano_spi_master.sv
// SPI mode-0 master, MSB first, CS held across multi-byte frames.
// Define NANO_SPI_RX_EN to build the MISO receive path.
module nano_spi_master
  import nano_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic [BYTE_W-1:0] TX_DATA,
  input  logic              TX_LAST,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [BYTE_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              BUSY,
  output logic              SPI_SCK,
  output logic              SPI_MOSI,
  output logic              SPI_CS,
  input  logic              SPI_MISO
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

  state_t state, state_n;

  logic [BYTE_W-1:0] tx_sh;
  logic [BIT_W-1:0]  bitcnt;
  logic              last;
  logic              sck;
  logic              cs;
  logic              mosi;
  logic              tick;
  logic              load;
  logic              hs;
  logic              rise;
  logic              fall;

  assign TX_READY = (state == IDLE) || (state == WAIT);
  assign hs       = TX_VALID && TX_READY;
  assign BUSY     = (state != IDLE);

  // Reload on every SCK edge and on every state entry.
  assign load = (state_n != state) || rise || fall;

  nano_spi_halfcnt #(
    .W(8)
  ) u_halfcnt (
    .clk     (CLK),
    .rst_n   (NRST),
    .load    (load),
    .load_val(DIV_M1),
    .tick    (tick)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    rise    = 1'b0;
    fall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) state_n = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!sck) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bitcnt == LAST_BIT) begin
              state_n = last ? HOLD : WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (hs) state_n = SHIFT;
      end
      HOLD: begin
        if (tick) state_n = RECOV;
      end
      RECOV: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      tx_sh  <= '0;
      last   <= 1'b0;
      bitcnt <= '0;
      sck    <= 1'b0;
      cs     <= 1'b1;
      mosi   <= 1'b0;
    end else begin
      if (hs) begin
        tx_sh  <= TX_DATA;
        last   <= TX_LAST;
        mosi   <= TX_DATA[BYTE_W-1];
        bitcnt <= '0;
        cs     <= 1'b0;
      end
      if (rise) begin
        sck <= 1'b1;
      end
      if (fall) begin
        sck    <= 1'b0;
        tx_sh  <= tx_sh << 1;
        mosi   <= tx_sh[BYTE_W-2];
        bitcnt <= bitcnt + 1'b1;
      end
      if (state == HOLD && tick) begin
        cs <= 1'b1;
      end
    end
  end

  assign SPI_SCK  = sck;
  assign SPI_MOSI = mosi;
  assign SPI_CS   = cs;

`ifdef NANO_SPI_RX_EN
  logic [BYTE_W-1:0] rx_sh;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= fall && (bitcnt == LAST_BIT);
      if (rise) begin
        rx_sh <= (rx_sh << 1) | BYTE_W'(SPI_MISO);
      end
      if (fall && (bitcnt == LAST_BIT)) begin
        rx_data <= rx_sh;
      end
    end
  end

  assign RX_DATA  = rx_data;
  assign RX_VALID = rx_valid;
`else
  logic unused_miso;
  assign unused_miso = SPI_MISO;
  assign RX_DATA     = '0;
  assign RX_VALID    = 1'b0;
`endif

endmodule

// File: tb/tb_nano_spi_master.sv
// Directed bench for nano_spi_master at CLK_DIV=2 and CLK_DIV=1.
// Expects RX data only when NANO_SPI_RX_EN is defined.
module tb_nano_spi_master;

  logic       CLK = 1'b0;
  logic       NRST = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       miso = 1'b0;
  logic       sel = 1'b0;

  logic       rdy1, rxv1, busy1, sck1, mosi1, cs1;
  logic       rdy2, rxv2, busy2, sck2, mosi2, cs2;
  logic [7:0] rxd1, rxd2;
  logic       v1, v2;

  logic       rdy, rxv, busy, sck, mosi, cs;
  logic [7:0] rxd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign v2 = tx_valid && !sel;
  assign v1 = tx_valid && sel;

  nano_spi_master #(.CLK_DIV(2)) u2 (
    .CLK(CLK), .NRST(NRST),
    .TX_DATA(tx_data), .TX_LAST(tx_last),
    .TX_VALID(v2), .TX_READY(rdy2),
    .RX_DATA(rxd2), .RX_VALID(rxv2), .BUSY(busy2),
    .SPI_SCK(sck2), .SPI_MOSI(mosi2), .SPI_CS(cs2),
    .SPI_MISO(miso)
  );

  nano_spi_master #(.CLK_DIV(1)) u1 (
    .CLK(CLK), .NRST(NRST),
    .TX_DATA(tx_data), .TX_LAST(tx_last),
    .TX_VALID(v1), .TX_READY(rdy1),
    .RX_DATA(rxd1), .RX_VALID(rxv1), .BUSY(busy1),
    .SPI_SCK(sck1), .SPI_MOSI(mosi1), .SPI_CS(cs1),
    .SPI_MISO(miso)
  );

  assign rdy  = sel ? rdy1  : rdy2;
  assign rxv  = sel ? rxv1  : rxv2;
  assign rxd  = sel ? rxd1  : rxd2;
  assign busy = sel ? busy1 : busy2;
  assign sck  = sel ? sck1  : sck2;
  assign mosi = sel ? mosi1 : mosi2;
  assign cs   = sel ? cs1   : cs2;

  // Event log, stamped with the cycle count seen at the falling CLK edge.
  int         rise_t[$];
  logic       rise_m[$];
  int         fall_t[$];
  int         rxv_t[$];
  logic [7:0] rxv_d[$];
  int         csf_t[$];
  int         csr_t[$];
  int         rdy_t[$];
  int         hs_t[$];

  // Mode-0 slave: next MISO bit presented after each SCK falling edge.
  logic [7:0] sbyte = '0;
  logic [7:0] sq[$];
  int         sbit = 0;

  logic p_sck = 1'b0, p_cs = 1'b1, p_rdy = 1'b1;

  always @(negedge CLK) begin
    if (sck && !p_sck) begin
      rise_t.push_back(cyc);
      rise_m.push_back(mosi);
    end
    if (!sck && p_sck) begin
      fall_t.push_back(cyc);
      sbit = sbit + 1;
      if (sbit == 8) begin
        sbit = 0;
        if (sq.size() > 0) sbyte = sq.pop_front();
      end
    end
    miso = sbyte[7 - sbit];
    if (!cs && p_cs) csf_t.push_back(cyc);
    if (cs && !p_cs) csr_t.push_back(cyc);
    if (rdy && !p_rdy) rdy_t.push_back(cyc);
    if (rxv) begin
      rxv_t.push_back(cyc);
      rxv_d.push_back(rxd);
    end
    p_sck = sck;
    p_cs  = cs;
    p_rdy = rdy;
  end

  function automatic void chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endfunction

  function automatic void clear_log();
    rise_t.delete(); rise_m.delete(); fall_t.delete();
    rxv_t.delete(); rxv_d.delete();
    csf_t.delete(); csr_t.delete(); rdy_t.delete(); hs_t.delete();
  endfunction

  task automatic send(input logic [7:0] b, input logic l, input logic hold);
    int w = 0;
    tx_data  = b;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!rdy && w < 500) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 500) chk("handshake_timeout", w, 0);
    hs_t.push_back(cyc);
    @(negedge CLK);
    tx_data = 8'($urandom);
    tx_last = 1'($urandom);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    chk("idle_timeout", int'(w < 2000), 1);
  endtask

  task automatic check_frame(input int n, input int d,
                             input logic [23:0] tx,
                             input logic [23:0] rx);
    int hl;
    chk("hs_count", hs_t.size(), n);
    if (hs_t.size() != n) return;
    hl = hs_t[n-1];
    chk("sck_rises", rise_t.size(), 8 * n);
    chk("sck_falls", fall_t.size(), 8 * n);
    if (rise_t.size() == 8 * n && fall_t.size() == 8 * n) begin
      for (int j = 0; j < n; j++) begin
        logic [7:0] got = '0;
        int bad = 0;
        for (int k = 1; k <= 8; k++) begin
          got = {got[6:0], rise_m[8*j+k-1]};
          if (rise_t[8*j+k-1] - hs_t[j] != 1 + (2*k - 1) * d) bad++;
          if (fall_t[8*j+k-1] - hs_t[j] != 1 + 2 * k * d) bad++;
        end
        chk("mosi_byte", got, tx[23-8*j -: 8]);
        chk("sck_edge_timing", bad, 0);
      end
    end
`ifdef NANO_SPI_RX_EN
    chk("rx_pulses", rxv_t.size(), n);
    if (rxv_t.size() == n) begin
      for (int j = 0; j < n; j++) begin
        chk("rx_valid_cycle", rxv_t[j] - hs_t[j], 1 + 16 * d);
        chk("rx_byte", rxv_d[j], rx[23-8*j -: 8]);
      end
    end
    chk("rx_data_hold", rxd, rx[23-8*(n-1) -: 8]);
`else
    chk("rx_pulses", rxv_t.size(), 0);
    chk("rx_data_tied", rxd, 0);
`endif
    chk("cs_falls", csf_t.size(), 1);
    chk("cs_rises", csr_t.size(), 1);
    if (csf_t.size() == 1) chk("cs_low_cycle", csf_t[0] - hs_t[0], 1);
    if (csr_t.size() == 1) chk("cs_high_cycle", csr_t[0] - hl, 1 + 17 * d);
    if (rdy_t.size() > 0)
      chk("ready_cycle", rdy_t[rdy_t.size()-1] - hl, 1 + 18 * d);
    else
      chk("ready_seen", 0, 1);
  endtask

  typedef struct {
    int          d;
    int          n;
    logic [23:0] tx;
    logic [23:0] rx;
    int          stall;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    logic [23:0] rx = v.rx;
    logic [23:0] tx = v.tx;
    sel = (v.d == 1);
    @(negedge CLK);
    sq.delete();
    for (int j = 1; j < v.n; j++) sq.push_back(rx[23-8*j -: 8]);
    sbyte = rx[23:16];
    sbit  = 0;
    clear_log();
    for (int j = 0; j < v.n; j++) begin
      if (j > 0 && v.stall > 0) repeat (v.stall) @(negedge CLK);
      send(tx[23-8*j -: 8], j == v.n - 1, j < v.n - 1 && v.stall == 0);
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge CLK);
    check_frame(v.n, v.d, tx, rx);
    if (v.n > 1 && v.stall == 0)
      chk("byte_pitch", hs_t[1] - hs_t[0], 16 * v.d + 1);
  endtask

  initial begin
    int w;
    vt[0] = '{2, 1, 24'hA50000, 24'h3C0000, 0};
    vt[1] = '{2, 3, 24'h010283, 24'hC35A7E, 0};
    vt[2] = '{2, 2, 24'h966900, 24'h1EE100, 50};
    vt[3] = '{1, 2, 24'hFF0000, 24'h00FF00, 0};
    vt[4] = '{1, 3, 24'h00FF00, 24'hFF00FF, 0};
    vt[5] = '{2, 1, 24'h5A0000, 24'h810000, 0};

    repeat (3) @(negedge CLK);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_data", rxd, 0);
    chk("rst_rx_valid", rxv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rdy, 1);
    tx_valid = 1'b1;
    @(negedge CLK);
    chk("rst_no_handshake", busy, 0);
    tx_valid = 1'b0;
    NRST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Abort during the 5th SCK high phase.
    sel = 1'b0;
    @(negedge CLK);
    clear_log();
    sq.delete();
    sbyte = 8'h3C;
    sbit  = 0;
    send(8'hA5, 1'b1, 1'b0);
    w = 0;
    while (rise_t.size() < 5 && w < 300) begin
      @(negedge CLK);
      w++;
    end
    chk("abort_wait", int'(w < 300), 1);
    chk("abort_sck_high", sck, 1);
    #2 NRST = 1'b0;
    #1;
    chk("abort_cs", cs, 1);
    chk("abort_sck", sck, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx_data", rxd, 0);
    @(negedge CLK);
    NRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_rx_pulses", rxv_t.size(), 0);
    chk("abort_ready", rdy, 1);
    run_vec(vt[5]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
